// File: rtl/lab2_serial_logic_unit_if.sv
// Operand/result bundle for the bit-serial logic unit: the requester drives
// start/op/operands and the unit returns busy/done/result/parity.
interface lab2_serial_logic_unit_if #(parameter int WIDTH = 8);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] inA;
    logic [WIDTH-1:0] inB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] outResult;
    logic             outParity;

    modport master (output start, op, inA, inB,
                    input  busy, done, outResult, outParity);
    modport slave  (input  start, op, inA, inB,
                    output busy, done, outResult, outParity);
endinterface

// File: rtl/lab2_serial_logic_unit.sv
// Bit-serial logic unit: one NOR-only cell evaluates op on A/B, LSB first.
// Optional LAB_PARITY_EN adds a NOR-built running parity registered into outParity.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | one result bit per cycle, WIDTH cycles
//   DONE  | result registered, done pulse; start relatches
module lab2_serial_logic_unit #(
    parameter int WIDTH = 8
) (
    input logic                   clk,
    input logic                   reset,
    lab2_serial_logic_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;

    // NOR-only bit cell; every function is formed from the same operand bits
    logic a_bit, b_bit;
    logic na, nb, f_nor, f_or, f_and, f_nand, f_xor, f_xnor, f_buf;
    logic cell_bit;

    assign a_bit = a_q[0];
    assign b_bit = b_q[0];

    nor u_na   (na,     a_bit, a_bit);
    nor u_nb   (nb,     b_bit, b_bit);
    nor u_nor  (f_nor,  a_bit, b_bit);
    nor u_or   (f_or,   f_nor, f_nor);
    nor u_and  (f_and,  na,    nb);
    nor u_nand (f_nand, f_and, f_and);
    nor u_xor  (f_xor,  f_and, f_nor);
    nor u_xnor (f_xnor, f_xor, f_xor);
    nor u_buf  (f_buf,  na,    na);

    always_comb begin
        cell_bit = 1'b0;
        case (op_q)
            3'b000:  cell_bit = f_and;
            3'b001:  cell_bit = f_or;
            3'b010:  cell_bit = na;
            3'b011:  cell_bit = f_nor;
            3'b100:  cell_bit = f_nand;
            3'b101:  cell_bit = f_xor;
            3'b110:  cell_bit = f_xnor;
            default: cell_bit = f_buf;
        endcase
    end

`ifdef LAB_PARITY_EN
    logic par_q, par_d, par_out_q, par_out_d;
    logic p_nor, p_np, p_nr, p_and, par_x;

    nor u_p_nor (p_nor, par_q, cell_bit);
    nor u_p_np  (p_np,  par_q, par_q);
    nor u_p_nr  (p_nr,  cell_bit, cell_bit);
    nor u_p_and (p_and, p_np, p_nr);
    nor u_p_xor (par_x, p_and, p_nor);
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
`ifdef LAB_PARITY_EN
        par_d     = par_q;
        par_out_d = par_out_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    a_d     = bus.inA;
                    b_d     = bus.inB;
                    op_d    = bus.op;
                    cnt_d   = '0;
                    acc_d   = '0;
`ifdef LAB_PARITY_EN
                    par_d   = 1'b0;
`endif
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                acc_d = {cell_bit, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
`ifdef LAB_PARITY_EN
                par_d = par_x;
`endif
                if (cnt_q == CW'(WIDTH - 1)) begin
                    result_d  = {cell_bit, acc_q[WIDTH-1:1]};
`ifdef LAB_PARITY_EN
                    par_out_d = par_x;
`endif
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
`ifdef LAB_PARITY_EN
            par_q     <= 1'b0;
            par_out_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
`ifdef LAB_PARITY_EN
            par_q     <= par_d;
            par_out_q <= par_out_d;
`endif
        end
    end

    assign bus.busy      = (state_q == ST_RUN);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.outResult = result_q;
`ifdef LAB_PARITY_EN
    assign bus.outParity = par_out_q;
`else
    assign bus.outParity = 1'b0;
`endif
endmodule

// File: tb/tb_lab2_serial_logic_unit.sv
// Directed bench for lab2_serial_logic_unit: opcode vector table plus
// hand-written sequences for start-during-RUN, back-to-back, reset and WIDTH=32.
module tb_lab2_serial_logic_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lab2_serial_logic_unit_if #(.WIDTH(8))  bus8 ();
    lab2_serial_logic_unit_if #(.WIDTH(32)) bus32 ();

    lab2_serial_logic_unit #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .bus(bus8));
    lab2_serial_logic_unit #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .bus(bus32));

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
    } vec_t;

    vec_t vecs[12];

    function automatic logic exp_par(input logic [31:0] r);
`ifdef LAB_PARITY_EN
        return ^r;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic launch8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op    = op;
        bus8.inA   = a;
        bus8.inB   = b;
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.op    = 3'($urandom);
        bus8.inA   = 8'($urandom);
        bus8.inB   = 8'($urandom);
    endtask

    // Counts negedges until done (bounded), and how many of those had busy high
    task automatic wait_done(input bit sel32, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (((sel32 ? bus32.done : bus8.done) !== 1'b1) && lat < 200) begin
            if ((sel32 ? bus32.busy : bus8.busy) === 1'b1) busy_cnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int lat, bc, bad;
        logic [7:0] prev;

        vecs[0]  = '{3'b000, 8'hF0, 8'h3C, 8'h30};
        vecs[1]  = '{3'b000, 8'hA5, 8'h0F, 8'h05};
        vecs[2]  = '{3'b001, 8'hA5, 8'h0F, 8'hAF};
        vecs[3]  = '{3'b010, 8'hA5, 8'h0F, 8'h5A};
        vecs[4]  = '{3'b011, 8'hA5, 8'h0F, 8'h50};
        vecs[5]  = '{3'b100, 8'hA5, 8'h0F, 8'hFA};
        vecs[6]  = '{3'b101, 8'hA5, 8'h0F, 8'hAA};
        vecs[7]  = '{3'b110, 8'hA5, 8'h0F, 8'h55};
        vecs[8]  = '{3'b111, 8'hA5, 8'h0F, 8'hA5};
        vecs[9]  = '{3'b111, 8'h01, 8'h00, 8'h01};
        vecs[10] = '{3'b010, 8'hFE, 8'h55, 8'h01};
        vecs[11] = '{3'b101, 8'h07, 8'h00, 8'h07};

        bus8.start = 1'b0;  bus8.op = '0;  bus8.inA = '0;  bus8.inB = '0;
        bus32.start = 1'b0; bus32.op = '0; bus32.inA = '0; bus32.inB = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.outResult !== 8'h00 ||
                bus8.outParity !== 1'b0) bad++;
        end
        check("idle_quiet_cycles_bad", 64'(bad), 64'd0);

        for (int i = 0; i < 12; i++) begin
            launch8(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(1'b0, lat, bc);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd8);
            check($sformatf("v%0d_busy_cycles", i), 64'(bc), 64'd8);
            check($sformatf("v%0d_busy_at_done", i), 64'(bus8.busy), 64'd0);
            check($sformatf("v%0d_result", i), 64'(bus8.outResult), 64'(vecs[i].res));
            check($sformatf("v%0d_parity", i), 64'(bus8.outParity), 64'(exp_par(32'(vecs[i].res))));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 64'(bus8.done), 64'd0);
            check($sformatf("v%0d_result_hold", i), 64'(bus8.outResult), 64'(vecs[i].res));
        end

        // start during RUN is ignored; result register holds the previous answer
        prev = bus8.outResult;
        launch8(3'b000, 8'hF0, 8'h3C);
        repeat (3) @(negedge clk);
        check("run_result_hold", 64'(bus8.outResult), 64'(prev));
        bus8.start = 1'b1; bus8.op = 3'b001; bus8.inA = 8'hFF; bus8.inB = 8'hFF;
        @(negedge clk);
        bus8.start = 1'b0;
        wait_done(1'b0, lat, bc);
        check("ign_latency_rest", 64'(lat), 64'd4);
        check("ign_result", 64'(bus8.outResult), 64'h30);

        // back-to-back: start held through DONE, no IDLE cycle
        bus8.start = 1'b1; bus8.op = 3'b101; bus8.inA = 8'hA5; bus8.inB = 8'h0F;
        @(negedge clk);
        check("b2b_busy_no_idle", 64'(bus8.busy), 64'd1);
        check("b2b_result_hold", 64'(bus8.outResult), 64'h30);
        bus8.start = 1'b0;
        wait_done(1'b0, lat, bc);
        check("b2b_latency", 64'(lat), 64'd8);
        check("b2b_result", 64'(bus8.outResult), 64'hAA);
        @(negedge clk);

        // reset during RUN discards the operation and clears outputs
        launch8(3'b111, 8'h3C, 8'h00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 64'(bus8.busy), 64'd0);
        check("rst_done", 64'(bus8.done), 64'd0);
        check("rst_result", 64'(bus8.outResult), 64'h00);
        check("rst_parity", 64'(bus8.outParity), 64'd0);
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) bad++;
        end
        check("rst_stays_idle_bad", 64'(bad), 64'd0);
        launch8(3'b100, 8'hF0, 8'h3C);
        wait_done(1'b0, lat, bc);
        check("post_rst_latency", 64'(lat), 64'd8);
        check("post_rst_result", 64'(bus8.outResult), 64'hCF);
        check("post_rst_parity", 64'(bus8.outParity), 64'(exp_par(32'hCF)));

        // WIDTH=32 XOR
        @(negedge clk);
        bus32.start = 1'b1; bus32.op = 3'b101;
        bus32.inA = 32'hFFFF0000; bus32.inB = 32'h0F0F0F0F;
        @(negedge clk);
        bus32.start = 1'b0; bus32.inA = 32'h12345678; bus32.inB = 32'h9ABCDEF0;
        wait_done(1'b1, lat, bc);
        check("w32_latency", 64'(lat), 64'd32);
        check("w32_busy_cycles", 64'(bc), 64'd32);
        check("w32_result", 64'(bus32.outResult), 64'hF0F00F0F);
        check("w32_parity", 64'(bus32.outParity), 64'(exp_par(32'hF0F00F0F)));
        @(negedge clk);
        check("w32_done_pulse", 64'(bus32.done), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
